v_compress_encoder: RTL and testbench

V_COMPRESS_ENCODER -- requirements
Module: v_compress_encoder

---
 rtl/v_compress_encoder_pkg.sv | 25 ++
 rtl/v_compress_encoder_compress_dv.sv | 30 +++
 rtl/v_compress_encoder.sv | 154 +++++++++++++++
 tb/tb_v_compress_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/v_compress_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : v_compress_encoder_pkg
//  Description : Shared constants and FSM state type for the V-polynomial
//                4-bit compress/pack encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package v_compress_encoder_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int DV      = 4;
    localparam int V_BYTES = 128;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        LATCH = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/v_compress_encoder_compress_dv.sv
`default_nettype none
// ============================================================================
//  Module      : compress_dv
//  Description : Combinational reduce-then-compress of one coefficient to
//                DV bits: c = floor((16*x' + 1664) / Q) mod 16, where
//                x' = x - Q when x >= Q.
//  Revision    : 1.0 - initial release
// ============================================================================
module compress_dv
    import v_compress_encoder_pkg::*;
(
    input  logic [15:0]   i_x,
    output logic [DV-1:0] o_c
);

    logic        w_ge_q;
    logic [15:0] w_red;
    logic [16:0] w_num;

    // Single conditional subtract; legal inputs never exceed 2Q-1, so the
    // reduced value always fits in 12 bits and 16*x'+1664 fits in 17 bits.
    always_comb begin
        w_ge_q = (i_x >= 16'(KYBER_Q));
        w_red  = w_ge_q ? (i_x - 16'(KYBER_Q)) : i_x;
        w_num  = 17'({w_red, 4'b0000}) + 17'd1664;
        o_c    = DV'(w_num / 17'(KYBER_Q));
    end

endmodule
`default_nettype wire

// File: rtl/v_compress_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : v_compress_encoder
//  Description : Reads 256 coefficients from a registered-read register file,
//                compresses each to 4 bits and streams 128 packed bytes over a
//                valid/ready interface. Optional sticky out-of-range flag is
//                built only when V_ENC_RANGE_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module v_compress_encoder
    import v_compress_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        reg_read_enable,
    output logic [7:0]  reg_index,
    input  logic [15:0] reg_data,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        range_err
);

    enc_state_t      r_state;
    enc_state_t      w_state_nxt;
    logic [6:0]      r_k;
    logic [DV-1:0]   r_lo;
    logic [7:0]      r_byte;
    logic [7:0]      r_idx_hold;
    logic [DV-1:0]   w_c;

    // One compressor shared by both nibbles: reg_data carries the low
    // coefficient in RD_HI and the high coefficient in LATCH.
    compress_dv u_compress (
        .i_x (reg_data),
        .o_c (w_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt     = r_state;
        busy            = 1'b0;
        done            = 1'b0;
        reg_read_enable = 1'b0;
        reg_index       = r_idx_hold;
        byte_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RD_LO;
                end
            end
            RD_LO: begin
                busy            = 1'b1;
                reg_read_enable = 1'b1;
                reg_index       = {r_k, 1'b0};
                w_state_nxt     = RD_HI;
            end
            RD_HI: begin
                busy            = 1'b1;
                reg_read_enable = 1'b1;
                reg_index       = {r_k, 1'b1};
                w_state_nxt     = LATCH;
            end
            LATCH: begin
                busy        = 1'b1;
                w_state_nxt = OUT;
            end
            OUT: begin
                busy       = 1'b1;
                byte_valid = 1'b1;
                if (byte_ready) begin
                    w_state_nxt = (r_k == 7'(V_BYTES - 1)) ? DONE : RD_LO;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Byte counter, nibble capture, output byte and read-index hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= 7'd0;
            r_lo       <= '0;
            r_byte     <= 8'h00;
            r_idx_hold <= 8'h00;
        end else begin
            r_idx_hold <= reg_index;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_k <= 7'd0;
                    end
                end
                RD_HI: begin
                    r_lo <= w_c;
                end
                LATCH: begin
                    r_byte <= {w_c, r_lo};
                end
                OUT: begin
                    if (byte_ready && (r_k != 7'(V_BYTES - 1))) begin
                        r_k <= r_k + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign byte_out = r_byte;

`ifdef V_ENC_RANGE_CHECK_EN
    logic r_range_err;

    // Sticky flag: any coefficient read back at or above Q; cleared by a new
    // accepted start so each block reports independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_range_err <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_range_err <= 1'b0;
        end else if (((r_state == RD_HI) || (r_state == LATCH)) &&
                     (reg_data >= 16'(KYBER_Q))) begin
            r_range_err <= 1'b1;
        end
    end

    assign range_err = r_range_err;
`else
    assign range_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_v_compress_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_v_compress_encoder
//  Description : Self-checking bench for v_compress_encoder with a
//                behavioural reference model and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_v_compress_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, reg_read_enable, byte_valid, range_err;
    logic [7:0]  reg_index, byte_out;
    logic [15:0] reg_data;
    logic        byte_ready = 1'b1;

    logic [15:0] mem [256];
    logic [7:0]  cap [128];

    int errors = 0;
    int checks = 0;
    int mode = 0;
    int stall = 0;

    v_compress_encoder dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .reg_read_enable (reg_read_enable),
        .reg_index       (reg_index),
        .reg_data        (reg_data),
        .byte_out        (byte_out),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .range_err       (range_err)
    );

    always #5 clk = ~clk;

    // Registered-read coefficient store.
    always @(posedge clk) begin
        if (reg_read_enable) reg_data <= mem[reg_index];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cval(input int x);
        int r;
        r = (x >= 3329) ? x - 3329 : x;
        return ((16 * r + 1664) / 3329) % 16;
    endfunction

    function automatic logic [7:0] exp_byte(input int k);
        return 8'(cval(int'(mem[2*k])) + 16 * cval(int'(mem[2*k+1])));
    endfunction

    function automatic bit oob(input int k);
        return (mem[2*k] >= 16'd3329) || (mem[2*k+1] >= 16'd3329);
    endfunction

    function automatic bit rng_exp(input bit b);
`ifdef V_ENC_RANGE_CHECK_EN
        return b;
`else
        return 1'b0 & b;
`endif
    endfunction

    // Reference model state: bytes done, cycles into the current byte.
    int m_k = 0;
    int m_cnt = 0;
    bit m_run = 0, m_done = 0, m_rng = 0;
    bit p_rst = 1, p_start = 0, p_ready = 0, p_vexp = 0;

    // Compare process: advance the model by the last edge, then check outputs.
    always @(negedge clk) begin
        bit sd, rs, ev;
        sd = m_done; m_done = 0; rs = 0;
        if (p_rst) begin
            m_run = 0; m_k = 0; m_cnt = 0; m_rng = 0; rs = 1;
        end else if (m_run) begin
            if (p_vexp && p_ready) begin
                m_rng = m_rng | oob(m_k);
                m_k++; m_cnt = 1;
                if (m_k == 128) begin m_run = 0; m_done = 1; end
            end else begin
                m_cnt++;
            end
        end else if (!sd && p_start) begin
            m_run = 1; m_k = 0; m_cnt = 1; m_rng = 0;
        end
        ev = m_run && (m_cnt >= 4);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("byte_valid", byte_valid, ev);
        chk("read_en", reg_read_enable, m_run && (m_cnt <= 2));
        if (rs) begin
            chk("rst_byte_out", byte_out, 8'h00);
            chk("rst_index", reg_index, 8'h00);
        end
        if (m_run && (m_cnt <= 2)) chk("read_index", reg_index, 2*m_k + m_cnt - 1);
        if (ev) begin
            chk("byte_out", byte_out, exp_byte(m_k));
            chk("range_run", range_err, rng_exp(m_rng | oob(m_k)));
            if (byte_ready) cap[m_k] = byte_out;
        end
        if (!m_run) chk("range_idle", range_err, rng_exp(m_rng));
        p_rst = rst; p_start = start; p_ready = byte_ready; p_vexp = ev;
    end

    // Downstream ready generator.
    always begin
        @(posedge clk); #1;
        case (mode)
            1: begin byte_ready = ($urandom_range(0, 3) != 0); stall = 0; end
            2: begin
                if (m_k == 5 && stall < 10) begin
                    byte_ready = 1'b0;
                    if (byte_valid) stall++;
                end else begin
                    byte_ready = 1'b1;
                end
            end
            default: begin byte_ready = 1'b1; stall = 0; end
        endcase
    end

    task automatic run(input int md, input bit chk_len, input bit inj, input int abort_at);
        int n; bit got, ab;
        mode = md; n = 0; got = 0; ab = 0;
        @(posedge clk); #1 start = 1'b1;
        while (n < 4000 && !got && !ab) begin
            @(posedge clk); #1;
            n++;
            start = inj && (n == 100);
            if (abort_at >= 0 && m_k == abort_at && m_run) begin
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                ab = 1;
            end else begin
                @(negedge clk);
                got = done;
            end
        end
        start = 1'b0;
        if (!ab) begin
            chk("done_seen", got, 1);
            if (chk_len) chk("block_cycles", n, 513);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("model_1665", cval(1665), 8);
        chk("model_3328", cval(3328), 0);
        chk("model_104", cval(104), 0);
        chk("model_105", cval(105), 1);
        chk("model_6657", cval(6657), 0);

        // All-zero block, ready held high: full-rate timing.
        run(0, 1, 0, -1);
        chk("zero_byte0", cap[0], 8'h00);
        chk("zero_byte127", cap[127], 8'h00);

        // Random block with pinned corner values, stall at byte 5, stray start.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 6657));
        mem[0] = 16'd1665; mem[1] = 16'd3328; mem[2] = 16'd104; mem[3] = 16'd105;
        mem[4] = 16'd0;    mem[5] = 16'd0;    mem[6] = 16'd0;   mem[7] = 16'd3329;
        run(2, 0, 1, -1);
        chk("lit_byte0", cap[0], 8'h08);
        chk("lit_byte1", cap[1], 8'h10);
        chk("lit_byte3", cap[3], 8'h00);
`ifdef V_ENC_RANGE_CHECK_EN
        chk("lit_range_set", range_err, 1);
`else
        chk("lit_range_off", range_err, 0);
`endif

        // In-range block with random backpressure, aborted by reset at byte 60.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 3328));
        run(1, 0, 0, 60);
        repeat (30) @(posedge clk);
        chk("abort_idle_busy", busy, 0);

        // Fresh start after abort must deliver all 128 bytes at full rate.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 6657));
        run(0, 1, 0, -1);
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
